reg_pipe: RTL and testbench

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe_if.sv | 30 +++
 rtl/reg_pipe.sv | 63 ++++++
 tb/tb_reg_pipe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_pipe_if.sv
// Bus bundle for reg_pipe: advance/clear controls, input word, and the registered outputs.
// With REG_PIPE_TAP_EN defined, per-stage taps and tap_valid are added.
interface reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    count;
`ifdef REG_PIPE_TAP_EN
  logic [WIDTH*DEPTH-1:0] taps;
  logic [DEPTH-1:0]       tap_valid;

  modport master (output en, clr, d, d_valid,
                  input  q, q_valid, count, taps, tap_valid);
  modport slave  (input  en, clr, d, d_valid,
                  output q, q_valid, count, taps, tap_valid);
`else
  modport master (output en, clr, d, d_valid,
                  input  q, q_valid, count);
  modport slave  (input  en, clr, d, d_valid,
                  output q, q_valid, count);
`endif
endinterface

// File: rtl/reg_pipe.sv
// DEPTH-stage enabled register pipeline with per-stage valid bits and a registered population count.
// Optional feature: define REG_PIPE_TAP_EN to expose every stage on taps/tap_valid.
module reg_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  reg_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt;

  // Net population change on an advance: one entry in at stage 0, one out of the last stage.
  // The saturating guards keep count inside 0..DEPTH even if the invariant were ever broken.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives count_nxt and no latch is inferred.
    count_nxt = count_r;
    if (bus.d_valid && !valid[DEPTH-1]) begin
      if (count_r != CW'(DEPTH)) count_nxt = count_r + CW'(1);
    end else if (!bus.d_valid && valid[DEPTH-1]) begin
      if (count_r != '0) count_nxt = count_r - CW'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples its predecessor's old value.
  // NOTE: the data stages are a register array, not RAM, so each is reset to RST_VAL explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      valid   <= '0;
      count_r <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      valid   <= '0;
      count_r <= '0;
    end else if (bus.en) begin
      stage[0] <= bus.d;
      valid[0] <= bus.d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
        valid[i] <= valid[i-1];
      end
      count_r <= count_nxt;
    end
  end

  assign bus.q       = stage[DEPTH-1];
  assign bus.q_valid = valid[DEPTH-1];
  assign bus.count   = count_r;

`ifdef REG_PIPE_TAP_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    assign bus.taps[g*WIDTH +: WIDTH] = stage[g];
  end
  assign bus.tap_valid = valid;
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// Randomized and directed bench for reg_pipe (DEPTH=4 and DEPTH=1 instances side by side).
// A queue-based model predicts every stage; a scoreboard checks the order of valid words leaving the pipe.
module tb_reg_pipe;
  localparam logic [7:0] RST4 = 8'h5A;
  localparam logic [7:0] RST1 = 8'hC3;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clr = 1'b0, d_valid = 1'b0;
  logic [7:0] d = '0;

  int total = 0;
  int bad   = 0;

  ent_t       m4[$];
  ent_t       m1[$];
  logic [7:0] sb4[$];
  bit         adv = 1'b0;

  reg_pipe_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  reg_pipe_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  assign bus4.en = en;  assign bus4.clr = clr;  assign bus4.d = d;  assign bus4.d_valid = d_valid;
  assign bus1.en = en;  assign bus1.clr = clr;  assign bus1.d = d;  assign bus1.d_valid = d_valid;

  reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RST4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  reg_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RST1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #30 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pop_count4();
    int n = 0;
    foreach (m4[i]) if (m4[i].v) n++;
    return n;
  endfunction

  task automatic model_clear();
    m4.delete();
    m1.delete();
    sb4.delete();
    repeat (4) m4.push_back('{v: 1'b0, d: RST4});
    m1.push_back('{v: 1'b0, d: RST1});
  endtask

  // One clock: present inputs, let the edge happen, then advance the model the same way.
  task automatic step(input logic e, input logic c, input logic [7:0] dd, input logic dv);
    en = e; clr = c; d = dd; d_valid = dv;
    @(posedge clk);
    if (c) begin
      model_clear();
      adv = 1'b0;
    end else if (e) begin
      m4.push_front('{v: dv, d: dd});
      void'(m4.pop_back());
      m1.push_front('{v: dv, d: dd});
      void'(m1.pop_back());
      if (dv) sb4.push_back(dd);
      adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_q4"},  bus4.q,       RST4);
    check({tag, "_qv4"}, bus4.q_valid, 1'b0);
    check({tag, "_c4"},  bus4.count,   3'd0);
    check({tag, "_q1"},  bus1.q,       RST1);
    check({tag, "_qv1"}, bus1.q_valid, 1'b0);
    check({tag, "_c1"},  bus1.count,   1'b0);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
  task automatic rst_pulse();
    #10 rst = 1'b1;
    #2 check_cleared("async_rst");
    model_clear();
    adv = 1'b0;
    #5 rst = 1'b0;
  endtask

  // Monitor: compares every output against the model and pops the scoreboard on each new valid word.
  initial begin
    forever begin
      @(negedge clk);
      check("q4",       bus4.q,       m4[3].d);
      check("q_valid4", bus4.q_valid, m4[3].v);
      check("count4",   bus4.count,   pop_count4());
      check("q1",       bus1.q,       m1[0].d);
      check("q_valid1", bus1.q_valid, m1[0].v);
      check("count1",   bus1.count,   m1[0].v);
`ifdef REG_PIPE_TAP_EN
      for (int i = 0; i < 4; i++) begin
        check("taps",      bus4.taps[i*8 +: 8],  m4[i].d);
        check("tap_valid", bus4.tap_valid[i],    m4[i].v);
      end
`endif
      if (adv && bus4.q_valid) begin
        if (sb4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb4_unexpected at %0t: got word %0h, expected no valid word", $time, bus4.q);
        end else begin
          check("sb4_order", bus4.q, sb4.pop_front());
        end
      end
      adv = 1'b0;
    end
  end

  initial begin
    logic [7:0] vals [5];
    logic       bub  [5];
    int         bub_cnt [5];
    vals    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bub     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bub_cnt = '{1, 1, 2, 2, 1};
    model_clear();

    // Reset held for 100 ns with inputs active; outputs must stay cleared throughout.
    en = 1'b1; d_valid = 1'b1; d = 8'hFF;
    #45 check_cleared("in_rst_a");
    #50 check_cleared("in_rst_b");
    #5 rst = 1'b0;

    // First edge after release behaves normally.
    step(1'b1, 1'b0, 8'h77, 1'b1);
    check("post_rst_c4", bus4.count,   3'd1);
    check("post_rst_q1", bus1.q,       8'h77);
    check("post_rst_v1", bus1.q_valid, 1'b1);

    // Streaming 0x11..0x55 then continued valid input.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, (k < 5) ? vals[k] : 8'(k), 1'b1);
      check("stream_count", bus4.count, (k + 1 > 4) ? 4 : k + 1);
      if (k >= 3) check("stream_q", bus4.q, vals[k-3]);
      check("stream_qv", bus4.q_valid, k >= 3);
    end

    // Stall: three held cycles after the 2nd edge.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 8'($urandom), 1'($urandom));
      check("stall_count", bus4.count,   3'd2);
      check("stall_qv",    bus4.q_valid, 1'b0);
    end
    step(1'b1, 1'b0, 8'h33, 1'b1);
    step(1'b1, 1'b0, 8'h44, 1'b1);
    check("stall_q_edge7",  bus4.q,       8'h11);
    check("stall_qv_edge7", bus4.q_valid, 1'b1);

    // Bubbles: d_valid 1,0,1,0,0.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0, 8'h90 + 8'(k), (k < 5) ? bub[k] : 1'b0);
      if (k < 5) check("bubble_count", bus4.count, bub_cnt[k]);
      if (k >= 3) check("bubble_qv", bus4.q_valid, bub[k-3]);
    end

    // Clear with en=1 while three entries are valid.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    check("pre_clr_count", bus4.count, 3'd3);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    check_cleared("clr");

    // Async reset pulse with entries in flight.
    step(1'b1, 1'b0, 8'h3C, 1'b1);
    step(1'b1, 1'b0, 8'h4D, 1'b1);
    rst_pulse();

    // DEPTH=1 single register behaviour.
    step(1'b1, 1'b0, 8'hA5, 1'b1);
    check("d1_q",     bus1.q,       8'hA5);
    check("d1_qv",    bus1.q_valid, 1'b1);
    check("d1_count", bus1.count,   1'b1);
`ifdef REG_PIPE_TAP_EN
    step(1'b1, 1'b0, 8'hB6, 1'b1);
    check("tap_stage1", bus4.taps[15:8], 8'hA5);
`endif

    // Randomized traffic with occasional clear, stall and reset.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 49) == 0) rst_pulse();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
